// File: rtl/sdram_ctrl_module.sv
// sdram_ctrl_module: command-level SDRAM controller sitting behind the init stage.
// It runs init once after reset, then arbitrates auto-refresh, user writes and user reads.
// It issues one-hot start strobes to the function stage and returns a done pulse per transfer.
//
// state  | meaning
// INIT   | init stage running, Init_Start_Sig held until Init_Done_Sig
// IDLE   | waiting; one-cycle priority decision AREF > WRITE > READ
// AREF   | auto-refresh command in flight (Func_Start_Sig = 3'b100)
// WRITE  | user write in flight (Func_Start_Sig = 3'b001)
// READ   | user read in flight (Func_Start_Sig = 3'b010)
module sdram_ctrl_module #(
    parameter int unsigned T15US = 11'd1500,
    parameter int unsigned CNT_W = 11
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WrEN_Sig,
    input  logic       RdEN_Sig,
    output logic       Done_Sig,
    output logic       Busy_Sig,
    output logic       Init_Start_Sig,
    input  logic       Init_Done_Sig,
    output logic [2:0] Func_Start_Sig,
    input  logic       Func_Done_Sig
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam logic [2:0] FS_AREF  = 3'b100;
    localparam logic [2:0] FS_READ  = 3'b010;
    localparam logic [2:0] FS_WRITE = 3'b001;

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(T15US - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] ref_cnt;
    logic             ref_pending;
    logic             ref_expire;
    logic             take_aref;

    // Refresh interval expiry and the IDLE-cycle decision to serve a pending refresh.
    always_comb begin
        ref_expire = (state != S_INIT) && (ref_cnt == REF_LAST);
        take_aref  = (state == S_IDLE) && ref_pending;
    end

    // Refresh interval counter with a sticky, single-depth pending flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (state == S_INIT)
                ref_cnt <= '0;
            else if (ref_expire)
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + CNT_W'(1);

            // A new expiry on the same edge as the refresh launch wins, so it is not lost.
            if (ref_expire)
                ref_pending <= 1'b1;
            else if (take_aref)
                ref_pending <= 1'b0;
        end
    end

    // Command FSM with registered strobes, busy and done outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_INIT;
            Init_Start_Sig <= 1'b0;
            Func_Start_Sig <= 3'b000;
            Done_Sig       <= 1'b0;
            Busy_Sig       <= 1'b1;
        end else begin
            Done_Sig <= 1'b0;
            case (state)
                S_INIT: begin
                    if (Init_Done_Sig) begin
                        Init_Start_Sig <= 1'b0;
                        state          <= S_IDLE;
                        Busy_Sig       <= 1'b0;
                    end else begin
                        Init_Start_Sig <= 1'b1;
                    end
                end
                S_IDLE: begin
                    // While Done_Sig is high the user still holds the old request level.
                    if (ref_pending) begin
                        state          <= S_AREF;
                        Func_Start_Sig <= FS_AREF;
                        Busy_Sig       <= 1'b1;
                    end else if (!Done_Sig && WrEN_Sig) begin
                        state          <= S_WRITE;
                        Func_Start_Sig <= FS_WRITE;
                        Busy_Sig       <= 1'b1;
                    end else if (!Done_Sig && RdEN_Sig) begin
                        state          <= S_READ;
                        Func_Start_Sig <= FS_READ;
                        Busy_Sig       <= 1'b1;
                    end
                end
                S_AREF, S_WRITE, S_READ: begin
                    if (Func_Done_Sig) begin
                        Func_Start_Sig <= 3'b000;
                        state          <= S_IDLE;
                        Busy_Sig       <= 1'b0;
                        Done_Sig       <= (state != S_AREF);
                    end
                end
                default: begin
                    state          <= S_INIT;
                    Init_Start_Sig <= 1'b0;
                    Func_Start_Sig <= 3'b000;
                    Busy_Sig       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ctrl_module.sv
// Directed bench for sdram_ctrl_module with T15US=20 and simple init/function stage models.
module tb_sdram_ctrl_module;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WrEN_Sig = 1'b0;
    logic       RdEN_Sig = 1'b0;
    logic       Done_Sig;
    logic       Busy_Sig;
    logic       Init_Start_Sig;
    logic       Init_Done_Sig = 1'b0;
    logic [2:0] Func_Start_Sig;
    logic       Func_Done_Sig = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int icnt = 0;
    int fcnt = 0;
    int func_lat = 10;
    int fd_cyc = 0;

    logic [2:0] prev_fs = 3'b000;
    int n_wr, n_rd, n_ar, n_done, illegal;
    int wr_cyc, rd_cyc, ar_cyc;
    int seq[$];

    sdram_ctrl_module #(.T15US(20), .CNT_W(11)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .WrEN_Sig       (WrEN_Sig),
        .RdEN_Sig       (RdEN_Sig),
        .Done_Sig       (Done_Sig),
        .Busy_Sig       (Busy_Sig),
        .Init_Start_Sig (Init_Start_Sig),
        .Init_Done_Sig  (Init_Done_Sig),
        .Func_Start_Sig (Func_Start_Sig),
        .Func_Done_Sig  (Func_Done_Sig)
    );

    always #5 CLK = ~CLK;

    // Cycle number: 0 while in reset, n on the n-th edge after release.
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    // Init stage model: done pulse on the 30th cycle of an asserted start.
    always @(negedge CLK) begin
        if (RST || !Init_Start_Sig) begin
            icnt = 0;
            Init_Done_Sig = 1'b0;
        end else begin
            icnt = icnt + 1;
            Init_Done_Sig = (icnt == 30);
        end
    end

    // Function stage model: done pulse func_lat cycles after a start appears.
    always @(negedge CLK) begin
        if (RST || Func_Start_Sig == 3'b000) begin
            fcnt = 0;
            Func_Done_Sig = 1'b0;
        end else begin
            fcnt = fcnt + 1;
            Func_Done_Sig = (fcnt == func_lat);
            if (Func_Done_Sig) fd_cyc = cyc;
        end
    end

    // Event recorder: command starts, done pulses, strobe legality.
    always @(negedge CLK) begin
        if (Func_Start_Sig != 3'b000 && prev_fs == 3'b000) begin
            case (Func_Start_Sig)
                3'b001: begin n_wr++; wr_cyc = cyc; seq.push_back(1); end
                3'b010: begin n_rd++; rd_cyc = cyc; seq.push_back(2); end
                3'b100: begin n_ar++; ar_cyc = cyc; seq.push_back(4); end
                default: illegal++;
            endcase
        end
        if (Done_Sig) n_done++;
        if (!$onehot0(Func_Start_Sig) || (Init_Start_Sig && Func_Start_Sig != 3'b000)) illegal++;
        prev_fs = Func_Start_Sig;
    end

    task automatic tick;
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_counts;
        n_wr = 0; n_rd = 0; n_ar = 0; n_done = 0; illegal = 0;
        wr_cyc = -1; rd_cyc = -1; ar_cyc = -1;
        seq.delete();
    endtask

    // Reset then run init; returns one sample after the edge that leaves INIT (cycle 31).
    task automatic init_seq;
        int guard;
        RST = 1'b1; WrEN_Sig = 1'b0; RdEN_Sig = 1'b0;
        tick; tick;
        RST = 1'b0;
        guard = 0;
        tick;
        while (Init_Start_Sig && guard < 60) begin tick; guard++; end
        total++;
        if (guard >= 60) begin bad++; $display("FAIL init_timeout: Init_Start_Sig still high at cycle %0d", cyc); end
        clear_counts();
    endtask

    task automatic wait_done(input int limit, input string name);
        int guard = 0;
        while (!Done_Sig && guard < limit) begin tick; guard++; end
        if (guard >= limit) begin
            total++; bad++;
            $display("FAIL %s_timeout: no Done_Sig within %0d cycles", name, limit);
        end
    endtask

    task automatic test_reset;
        bit init_err = 0, fs_err = 0;
        RST = 1'b1;
        tick;
        total++; if (Init_Start_Sig !== 1'b0) begin bad++; $display("FAIL rst_init_start: got %b want 0", Init_Start_Sig); end
        total++; if (Func_Start_Sig !== 3'b000) begin bad++; $display("FAIL rst_func_start: got %b want 000", Func_Start_Sig); end
        total++; if (Done_Sig !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", Done_Sig); end
        total++; if (Busy_Sig !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", Busy_Sig); end
        clear_counts();
        RST = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (Init_Start_Sig !== 1'b1 || Busy_Sig !== 1'b1) init_err = 1;
            if (Func_Start_Sig !== 3'b000) fs_err = 1;
        end
        total++; if (init_err) begin bad++; $display("FAIL init_start_window: Init_Start/Busy not high through cycles 1..30 (got %b/%b at end)", Init_Start_Sig, Busy_Sig); end
        total++; if (fs_err) begin bad++; $display("FAIL init_no_func: got Func_Start nonzero during init, want 000"); end
        tick;
        total++; if (Init_Start_Sig !== 1'b0) begin bad++; $display("FAIL init_release: got %b want 0 at cycle 31", Init_Start_Sig); end
        total++; if (Busy_Sig !== 1'b0) begin bad++; $display("FAIL init_busy_low: got %b want 0 at cycle 31", Busy_Sig); end
    endtask

    task automatic test_write;
        init_seq();
        func_lat = 10;
        WrEN_Sig = 1'b1;
        tick;
        total++; if (Func_Start_Sig !== 3'b001) begin bad++; $display("FAIL wr_start: got %b want 001", Func_Start_Sig); end
        total++; if (wr_cyc !== 32) begin bad++; $display("FAIL wr_start_cycle: got %0d want 32", wr_cyc); end
        wait_done(40, "wr");
        total++; if (cyc !== 42) begin bad++; $display("FAIL wr_done_cycle: got %0d want 42", cyc); end
        total++; if (cyc !== fd_cyc + 1) begin bad++; $display("FAIL wr_done_latency: got %0d want %0d", cyc, fd_cyc + 1); end
        WrEN_Sig = 1'b0;
        tick;
        total++; if (Done_Sig !== 1'b0) begin bad++; $display("FAIL wr_done_pulse: got %b want 0", Done_Sig); end
        while (cyc < 49) tick;
        total++; if (n_wr !== 1 || n_done !== 1) begin bad++; $display("FAIL wr_single: got wr=%0d done=%0d want 1/1", n_wr, n_done); end
        total++; if (Busy_Sig !== 1'b0) begin bad++; $display("FAIL wr_idle_busy: got %b want 0", Busy_Sig); end
    endtask

    task automatic test_back_to_back;
        init_seq();
        func_lat = 3;
        WrEN_Sig = 1'b1;
        RdEN_Sig = 1'b1;
        tick;
        total++; if (Func_Start_Sig !== 3'b001) begin bad++; $display("FAIL b2b_first: got %b want 001", Func_Start_Sig); end
        wait_done(20, "b2b_wr");
        total++; if (cyc !== 35) begin bad++; $display("FAIL b2b_wr_done_cycle: got %0d want 35", cyc); end
        WrEN_Sig = 1'b0;
        tick;
        wait_done(20, "b2b_rd");
        total++; if (cyc !== 40) begin bad++; $display("FAIL b2b_rd_done_cycle: got %0d want 40", cyc); end
        RdEN_Sig = 1'b0;
        total++; if (rd_cyc !== 37) begin bad++; $display("FAIL b2b_rd_start_cycle: got %0d want 37", rd_cyc); end
        while (cyc < 46) tick;
        total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        total++; if (seq.size() !== 2 || seq[0] !== 1 || seq[1] !== 2) begin bad++; $display("FAIL b2b_order: got size=%0d want WR then RD", seq.size()); end
    endtask

    task automatic test_refresh_defer;
        int guard = 0;
        init_seq();
        while (cyc < 40) tick;
        func_lat = 25;
        RdEN_Sig = 1'b1;
        wait_done(40, "ref_rd");
        total++; if (cyc !== 66) begin bad++; $display("FAIL ref_rd_done_cycle: got %0d want 66", cyc); end
        RdEN_Sig = 1'b0;
        WrEN_Sig = 1'b1;
        func_lat = 3;
        while (n_wr == 0 && guard < 20) begin tick; guard++; end
        total++; if (ar_cyc !== 67) begin bad++; $display("FAIL ref_aref_cycle: got %0d want 67", ar_cyc); end
        total++; if (wr_cyc !== 71) begin bad++; $display("FAIL ref_wr_cycle: got %0d want 71", wr_cyc); end
        total++; if (seq.size() < 3 || seq[0] !== 2 || seq[1] !== 4 || seq[2] !== 1 || n_ar !== 1) begin
            bad++; $display("FAIL ref_order: got size=%0d ar=%0d want RD,AR,WR with one AR", seq.size(), n_ar);
        end
        wait_done(20, "ref_wr");
        WrEN_Sig = 1'b0;
        tick;
    endtask

    task automatic test_stall;
        init_seq();
        func_lat = 50;
        WrEN_Sig = 1'b1;
        wait_done(70, "stall_wr");
        total++; if (cyc !== 82) begin bad++; $display("FAIL stall_done_cycle: got %0d want 82", cyc); end
        WrEN_Sig = 1'b0;
        func_lat = 2;
        while (cyc < 90) tick;
        total++; if (n_ar !== 1) begin bad++; $display("FAIL stall_aref_count: got %0d want 1", n_ar); end
        total++; if (ar_cyc !== 83) begin bad++; $display("FAIL stall_aref_cycle: got %0d want 83", ar_cyc); end
        total++; if (n_wr !== 1 || n_done !== 1) begin bad++; $display("FAIL stall_user: got wr=%0d done=%0d want 1/1", n_wr, n_done); end
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        init_seq();
        func_lat = 50;
        WrEN_Sig = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        total++; if (Func_Start_Sig !== 3'b001) begin bad++; $display("FAIL mid_in_write: got %b want 001", Func_Start_Sig); end
        RST = 1'b1;
        WrEN_Sig = 1'b0;
        tick;
        total++; if (Func_Start_Sig !== 3'b000) begin bad++; $display("FAIL mid_func_drop: got %b want 000", Func_Start_Sig); end
        total++; if (Busy_Sig !== 1'b1 || Init_Start_Sig !== 1'b0) begin bad++; $display("FAIL mid_rst_state: got busy=%b init=%b want 1/0", Busy_Sig, Init_Start_Sig); end
        RST = 1'b0;
        tick;
        total++; if (Init_Start_Sig !== 1'b1) begin bad++; $display("FAIL mid_reinit: got %b want 1", Init_Start_Sig); end
        while (Init_Start_Sig && guard < 40) begin tick; guard++; end
        for (int i = 0; i < 5; i++) tick;
        total++; if (n_done !== 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", n_done); end
        total++; if (illegal !== 0) begin bad++; $display("FAIL strobe_legal: got %0d illegal samples want 0", illegal); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_write();
        test_back_to_back();
        test_refresh_defer();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
